// File: rtl/quad_step_ctrl_if.sv
// Encoder front-end bus: raw encoder/button pins in, counter control pulses out.
interface quad_step_ctrl_if;
  logic a_in;
  logic b_in;
  logic btn_in;
  logic en;
  logic up;
  logic clr;
  logic err;

  modport master (
    output a_in, b_in, btn_in,
    input  en, up, clr, err
  );

  modport slave (
    input  a_in, b_in, btn_in,
    output en, up, clr, err
  );
endinterface

// File: rtl/quad_step_ctrl.sv
// Quadrature encoder + clear button front end for an up/down counter.
// Raw pins are synchronised and debounced. Filtered A/B transitions are decoded
// and accumulated. One en pulse is issued per detent, and a debounced button
// press issues one clr pulse. All outputs are registered.
module quad_step_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int DETENT    = 4
) (
  input  logic             clk,
  input  logic             reset,
  quad_step_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int AW = $clog2(DETENT) + 1;

  localparam logic [CW-1:0]        CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic signed [AW-1:0] ACC_MAX  = AW'(DETENT - 1);
  localparam logic signed [AW-1:0] ACC_MIN  = AW'(1 - DETENT);
  localparam logic signed [AW-1:0] ACC_ONE  = AW'(1);

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_REV  = 2'b10;
  localparam logic [1:0] DIR_BAD  = 2'b11;

  // Successor of a {A,B} state in the forward cycle 00->01->11->10->00.
  function automatic logic [1:0] quad_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  // Classify a state change as forward, reverse, illegal (both bits flipped) or none.
  function automatic logic [1:0] quad_dir(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    if (cur == prev)                 d = DIR_NONE;
    else if (cur == quad_next(prev)) d = DIR_FWD;
    else if (prev == quad_next(cur)) d = DIR_REV;
    else                             d = DIR_BAD;
    return d;
  endfunction

  // Pin index: 0 = B, 1 = A, 2 = button.
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q, filt_q;
  logic [CW-1:0] cnt_q [3];

  assign raw = {bus.btn_in, bus.a_in, bus.b_in};

  // Stage 0/1: two-flop synchronisers, then per-pin stability counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            filt_q[i] <= sync2_q[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  logic                 en_q, up_q, clr_q, err_q;
  logic                 en_d, up_d, clr_d, err_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [1:0]           qs_q, qs_d;
  logic                 primed_q, primed_d;
  logic                 btn_prev_q;
  logic [1:0]           dir;
  logic                 btn_edge;

  assign dir      = quad_dir(qs_q, filt_q[1:0]);
  assign btn_edge = filt_q[2] & ~btn_prev_q;

  // Stage 2: decode filtered transitions, accumulate detents, resolve clear priority.
  always_comb begin
    en_d     = 1'b0;
    up_d     = up_q;
    clr_d    = 1'b0;
    err_d    = 1'b0;
    acc_d    = acc_q;
    qs_d     = qs_q;
    primed_d = primed_q;
    if (dir != DIR_NONE) begin
      qs_d = filt_q[1:0];
      if (!primed_q) begin
        // First settled state after reset is only recorded.
        primed_d = 1'b1;
      end else begin
        case (dir)
          DIR_FWD: begin
            if (acc_q == ACC_MAX) begin
              en_d  = 1'b1;
              up_d  = 1'b1;
              acc_d = '0;
            end else begin
              acc_d = acc_q + ACC_ONE;
            end
          end
          DIR_REV: begin
            if (acc_q == ACC_MIN) begin
              en_d  = 1'b1;
              up_d  = 1'b0;
              acc_d = '0;
            end else begin
              acc_d = acc_q - ACC_ONE;
            end
          end
          default: begin
            err_d = 1'b1;
            acc_d = '0;
          end
        endcase
      end
    end
    if (btn_edge) begin
      // Clear wins over a completing step; direction keeps its last value.
      clr_d = 1'b1;
      en_d  = 1'b0;
      up_d  = up_q;
      acc_d = '0;
    end
  end

  // Stage 3: registered outputs and decoder state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q       <= 1'b0;
      up_q       <= 1'b0;
      clr_q      <= 1'b0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      qs_q       <= '0;
      primed_q   <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      en_q       <= en_d;
      up_q       <= up_d;
      clr_q      <= clr_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
      qs_q       <= qs_d;
      primed_q   <= primed_d;
      btn_prev_q <= filt_q[2];
    end
  end

  assign bus.en  = en_q;
  assign bus.up  = up_q;
  assign bus.clr = clr_q;
  assign bus.err = err_q;

endmodule
